compare_serial: RTL and testbench



---
 rtl/compare_pkg.sv | 37 +++
 rtl/compare_serial_if.sv | 25 ++
 rtl/add_chunk_cin_cout.sv | 24 ++
 rtl/compare_serial.sv | 119 +++++++++++
 tb/tb_compare_serial.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/compare_pkg.sv
// Shared encodings for compare_serial: relation modes, FSM states and the
// mapping from the final carry/zero flags to the selected relation.
package compare_pkg;

  typedef enum logic [2:0] {
    CMP_GT = 3'd0,
    CMP_GE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } cmp_state_t;

  // ge is the final carry of A + ~B + 1; reserved modes read as 0.
  function automatic logic cmp_result(input logic [2:0] mode,
                                      input logic       ge,
                                      input logic       eq);
    logic gt;
    gt = ge & ~eq;
    case (mode)
      CMP_GT:  return gt;
      CMP_GE:  return ge;
      CMP_LT:  return ~ge;
      CMP_LE:  return ~gt;
      CMP_EQ:  return eq;
      CMP_NE:  return ~eq;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/compare_serial_if.sv
// Request/result bundle for compare_serial; master drives requests, slave is
// the comparator.
interface compare_serial_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [2:0]       MODE;
  logic             SIGNED;
  logic             BUSY;
  logic             DONE;
  logic             O;
  logic             EQ;

  modport master (
    output START, I0, I1, MODE, SIGNED,
    input  BUSY, DONE, O, EQ
  );

  modport slave (
    input  START, I0, I1, MODE, SIGNED,
    output BUSY, DONE, O, EQ
  );
endinterface

// File: rtl/add_chunk_cin_cout.sv
// CHUNK-bit ripple adder with carry in/out, written as per-bit full adders so
// synthesis maps it onto the dedicated carry chain.
module add_chunk_cin_cout #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             CIN,
  output logic [CHUNK-1:0] S,
  output logic             COUT
);

  logic [CHUNK:0] c;

  assign c[0] = CIN;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign COUT = c[CHUNK];

endmodule

// File: rtl/compare_serial.sv
// Multi-cycle magnitude comparator: A + ~B + 1 evaluated CHUNK bits per cycle,
// LSB first. Define COMPARE_SERIAL_SIGNED_EN to honour the SIGNED input.
module compare_serial
  import compare_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  compare_serial_if.slave   bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  cmp_state_t        state;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              zero;
  logic              busy_r;
  logic              done_r;
  logic              o_r;
  logic              eq_r;

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [2:0]        mode_q;

  logic [CHUNK-1:0]  sum;
  logic              cout;
  logic              accept;
  logic              last;
  logic              eq_fin;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;

  assign accept = bus.START && (state != S_RUN);
  assign last   = (cnt == CW'(N - 1));
  assign eq_fin = zero & (sum == '0);

`ifdef COMPARE_SERIAL_SIGNED_EN
  // Flipping both sign bits turns two's-complement order into unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_in = bus.SIGNED ? (bus.I0 ^ MSB_MASK) : bus.I0;
  assign b_in = bus.SIGNED ? (bus.I1 ^ MSB_MASK) : bus.I1;
`else
  assign a_in = bus.I0;
  assign b_in = bus.I1;
`endif

  // Operand registers shift right so the active chunk is always at bit 0.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q    <= a_in;
      b_q    <= b_in;
      mode_q <= bus.MODE;
    end else if (state == S_RUN) begin
      a_q <= a_q >> CHUNK;
      b_q <= b_q >> CHUNK;
    end
  end

  add_chunk_cin_cout #(
    .CHUNK (CHUNK)
  ) u_add (
    .A    (a_q[CHUNK-1:0]),
    .B    (~b_q[CHUNK-1:0]),
    .CIN  (carry),
    .S    (sum),
    .COUT (cout)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b1;
      zero   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      o_r    <= 1'b0;
      eq_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_RUN: begin
          carry <= cout;
          zero  <= eq_fin;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state  <= S_FIN;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            o_r    <= cmp_result(mode_q, cout, eq_fin);
            eq_r   <= eq_fin;
          end
        end
        default: begin
          if (bus.START) begin
            state  <= S_RUN;
            cnt    <= '0;
            carry  <= 1'b1;
            zero   <= 1'b1;
            busy_r <= 1'b1;
          end else begin
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.BUSY = busy_r;
  assign bus.DONE = done_r;
  assign bus.O    = o_r;
  assign bus.EQ   = eq_r;

endmodule

// File: tb/tb_compare_serial.sv
// Bench for compare_serial: directed requests, an arithmetic reference model
// checked every cycle, and literal expectations for the listed scenarios.
module tb_compare_serial;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

`ifdef COMPARE_SERIAL_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compare_serial_if #(.WIDTH(WIDTH)) bus ();

  compare_serial #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_o(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [2:0] m, input logic s);
    logic gt, eq;
    eq = (a == b);
    gt = (s && SGN_EN) ? ($signed(a) > $signed(b)) : (a > b);
    case (m)
      3'd0:    return gt;
      3'd1:    return gt | eq;
      3'd2:    return ~gt & ~eq;
      3'd3:    return ~gt;
      3'd4:    return eq;
      3'd5:    return ~eq;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: a job runs for N edges after its accept; results are
  // published on the N-th edge and a new request is taken only when no job
  // is in flight.
  int               cyc    = 0;
  int               m_left = 0;
  logic             m_done = 1'b0;
  logic             m_o    = 1'b0;
  logic             m_eq   = 1'b0;
  logic [WIDTH-1:0] j_a, j_b;
  logic [2:0]       j_m;
  logic             j_s;
  int               acc_q[$];
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_o    = 1'b0;
      m_eq   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_o    = model_o(j_a, j_b, j_m, j_s);
          m_eq   = (j_a == j_b);
        end
      end else if (bus.START) begin
        j_a    = bus.I0;
        j_b    = bus.I1;
        j_m    = bus.MODE;
        j_s    = bus.SIGNED;
        m_left = N;
        acc_q.push_back(cyc);
      end
    end
    #1;
    if (chk_en) begin
      check("cyc_busy", 32'(bus.BUSY), 32'(m_left > 0));
      check("cyc_done", 32'(bus.DONE), 32'(m_done));
      check("cyc_o",    32'(bus.O),    32'(m_o));
      check("cyc_eq",   32'(bus.EQ),   32'(m_eq));
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] m, input logic s,
                        input logic exp_o, input logic exp_eq, input string nm);
    int lat, bcnt;
    @(negedge clk);
    bus.I0 = a; bus.I1 = b; bus.MODE = m; bus.SIGNED = s; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    bus.I0 = a ^ 16'hA5A5; bus.I1 = ~b; bus.MODE = m + 3'd1; bus.SIGNED = ~s;
    lat = 0; bcnt = 0;
    while (lat < 20) begin
      if (bus.BUSY) bcnt++;
      if (bus.DONE) break;
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"},  32'(lat),    32'(N));
    check({nm, "_busy"}, 32'(bcnt),   32'(N));
    check({nm, "_o"},    32'(bus.O),  32'(exp_o));
    check({nm, "_eq"},   32'(bus.EQ), 32'(exp_eq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, dcnt;
    rst = 1'b1;
    bus.START = 1'b0; bus.I0 = '0; bus.I1 = '0; bus.MODE = 3'd0; bus.SIGNED = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_o",    32'(bus.O),    32'd0);
    check("rst_eq",   32'(bus.EQ),   32'd0);
    rst = 1'b0;

    run_op(16'h8000, 16'h7FFF, 3'd0, 1'b0, 1'b1, 1'b0, "t1_ugt");
    run_op(16'h8000, 16'h7FFF, 3'd0, 1'b1, !SGN_EN, 1'b0, "t2_sgt");
    run_op(16'h8000, 16'h7FFF, 3'd2, 1'b1, SGN_EN,  1'b0, "t2_slt");
    run_op(16'h1234, 16'h1234, 3'd1, 1'b0, 1'b1, 1'b1, "t3_ge");
    run_op(16'h1234, 16'h1234, 3'd0, 1'b0, 1'b0, 1'b1, "t3_gt");
    run_op(16'h1234, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b1, "t3_ne");
    run_op(16'h0001, 16'h0100, 3'd3, 1'b0, 1'b1, 1'b0, "tx_le");
    run_op(16'hFFFE, 16'hFFFF, 3'd2, 1'b1, 1'b1, 1'b0, "tx_slt");

    // START held high with operands changing every cycle.
    n0 = acc_q.size();
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      bus.START  = 1'b1;
      bus.I0     = 16'(i * 4951) ^ 16'h8001;
      bus.I1     = 16'(i * 3871);
      bus.MODE   = 3'(i % 6);
      bus.SIGNED = 1'(i & 1);
    end
    @(negedge clk);
    bus.START = 1'b0;
    repeat (N + 2) @(negedge clk);
    check("t4_accepts", 32'(acc_q.size() - n0), 32'd3);
    if (acc_q.size() >= n0 + 3) begin
      check("t4_first", 32'(acc_q[n0]),                    32'(c0 + 1));
      check("t4_gap1",  32'(acc_q[n0+1] - acc_q[n0]),      32'd5);
      check("t4_gap2",  32'(acc_q[n0+2] - acc_q[n0+1]),    32'd5);
    end

    // Abort mid-run after a result that left O and EQ high.
    run_op(16'h0005, 16'h0005, 3'd1, 1'b0, 1'b1, 1'b1, "t5_pre");
    @(negedge clk);
    bus.I0 = 16'h0009; bus.I1 = 16'h0003; bus.MODE = 3'd0; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 32'(bus.BUSY), 32'd0);
    check("t5_o",    32'(bus.O),    32'd0);
    check("t5_eq",   32'(bus.EQ),   32'd0);
    rst = 1'b0;
    dcnt = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (bus.DONE) dcnt++;
    end
    check("t5_nodone", 32'(dcnt), 32'd0);

    run_op(16'h0005, 16'h0005, 3'd6, 1'b0, 1'b0, 1'b1, "t6_rsv");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
